// File: rtl/rs_ctrl_pkg.sv
// Shared types and the commit-broadcast forwarding rule used by dispatch and the
// reservation stations.
package rs_ctrl_pkg;

    localparam int unsigned CMD_W        = 10;
    localparam int unsigned OPND_W       = 65;
    localparam int unsigned OPND_RDY_BIT = 64;

    typedef logic [OPND_W-1:0] operand_t;

    // Tags are passed zero-extended so callers of any tag width can share this.
    function automatic operand_t fwd_operand(input operand_t    opnd,
                                             input logic [31:0] tag,
                                             input logic [31:0] bcast_tag,
                                             input operand_t    bcast_val);
        if (!opnd[OPND_RDY_BIT] && bcast_val[OPND_RDY_BIT] && (tag == bcast_tag)) begin
            return bcast_val;
        end
        return opnd;
    endfunction

endpackage

// File: rtl/rs_rr_select.sv
// Round-robin pick of the first non-stalled group, starting at the pointer.
module rs_rr_select #(
    parameter int unsigned  N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  stall_i,
    output logic          valid_o,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o  = 1'b0;
        index_o  = '0;
        cand     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!valid_o && !stall_i[cand]) begin
                valid_o = 1'b1;
                index_o = cand;
            end
        end
        onehot_o = valid_o ? (N'(1) << index_o) : '0;
    end

endmodule

// File: rtl/rs_dispatch_ctrl.sv
// One-entry dispatch buffer between decode and NUM_RS reservation-station groups,
// snooping the commit broadcast while held and steering round-robin to a free group.
module rs_dispatch_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int unsigned ROBsize    = 8,
    parameter int unsigned ROBsizeLog = $clog2(ROBsize + 1),
    parameter int unsigned NUM_RS     = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  decodeValid_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag1_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag2_i,
    input  logic [ROBsizeLog-1:0] decodeROBTag_i,
    input  logic [OPND_W-1:0]     decodeROBval1_i,
    input  logic [OPND_W-1:0]     decodeROBval2_i,
    input  logic [CMD_W-1:0]      decodeCommands_i,
    output logic                  decodeReady_o,
    input  logic [ROBsizeLog-1:0] issueROBTagCom_i,
    input  logic [OPND_W-1:0]     issueROBvalCom_i,
    input  logic [NUM_RS-1:0]     rsStall_i,
    output logic [NUM_RS-1:0]     rsWriteEn_o,
    output logic [ROBsizeLog-1:0] rsROBTag1_o,
    output logic [ROBsizeLog-1:0] rsROBTag2_o,
    output logic [ROBsizeLog-1:0] rsROBTag_o,
    output logic [OPND_W-1:0]     rsROBval1_o,
    output logic [OPND_W-1:0]     rsROBval2_o,
    output logic [CMD_W-1:0]      rsCommands_o,
    output logic [15:0]           dispatchCount_o
);

    localparam int unsigned IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    logic                  held_q;
    logic [ROBsizeLog-1:0] tag1_q, tag2_q, tag_q;
    operand_t              val1_q, val2_q;
    logic [CMD_W-1:0]      cmd_q;
    logic [IW-1:0]         rr_q;
    logic [15:0]           cnt_q;

    logic                  cand_valid;
    logic [NUM_RS-1:0]     cand_oh;
    logic [IW-1:0]         cand_idx;
    logic [IW-1:0]         rr_next;
    logic                  active, fire, accept;
    operand_t              fwd_val1, fwd_val2, dec_val1, dec_val2;

    rs_rr_select #(
        .N (NUM_RS)
    ) u_rr_select (
        .ptr_i    (rr_q),
        .stall_i  (rsStall_i),
        .valid_o  (cand_valid),
        .onehot_o (cand_oh),
        .index_o  (cand_idx)
    );

    always_comb begin
        fwd_val1 = fwd_operand(val1_q, 32'(tag1_q), 32'(issueROBTagCom_i), issueROBvalCom_i);
        fwd_val2 = fwd_operand(val2_q, 32'(tag2_q), 32'(issueROBTagCom_i), issueROBvalCom_i);
        dec_val1 = fwd_operand(decodeROBval1_i, 32'(decodeROBTag1_i), 32'(issueROBTagCom_i),
                               issueROBvalCom_i);
        dec_val2 = fwd_operand(decodeROBval2_i, 32'(decodeROBTag2_i), 32'(issueROBTagCom_i),
                               issueROBvalCom_i);

        // Reset must suppress a write even in the first cycle it is asserted.
        active        = held_q & ~reset_i;
        fire          = active & cand_valid & ~flush_i;
        decodeReady_o = ~reset_i & ~flush_i & (~held_q | fire);
        accept        = decodeValid_i & decodeReady_o;
        rr_next       = (cand_idx == IW'(NUM_RS - 1)) ? '0 : cand_idx + 1'b1;

        rsWriteEn_o     = fire ? cand_oh : '0;
        rsROBTag1_o     = active ? tag1_q : '0;
        rsROBTag2_o     = active ? tag2_q : '0;
        rsROBTag_o      = active ? tag_q : '0;
        rsROBval1_o     = active ? fwd_val1 : '0;
        rsROBval2_o     = active ? fwd_val2 : '0;
        rsCommands_o    = active ? cmd_q : '0;
        dispatchCount_o = reset_i ? '0 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_q <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
            tag_q  <= '0;
            val1_q <= '0;
            val2_q <= '0;
            cmd_q  <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (fire) begin
                rr_q <= rr_next;
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
            end
            if (accept) begin
                held_q <= 1'b1;
                tag1_q <= decodeROBTag1_i;
                tag2_q <= decodeROBTag2_i;
                tag_q  <= decodeROBTag_i;
                val1_q <= dec_val1;
                val2_q <= dec_val2;
                cmd_q  <= decodeCommands_i;
            end else if (fire || flush_i) begin
                held_q <= 1'b0;
            end else if (held_q) begin
                val1_q <= fwd_val1;
                val2_q <= fwd_val2;
            end
        end
    end

endmodule
